wash_billing_n: RTL and testbench
=================================

# wash_billing_n

Parametrised billing controller for the washing-machine front end, successor to the fixed four-mode billing FSM. Latches a price from an N-entry BCD table, shows balance and price alternately, deducts on confirmation, then runs a pickup-grace countdown on the water-light bar and charges a repeating idle fine once grace expires. It drives the shared scan4 digit bus, status and bar lights, buzzer enable, and a balance write-back to the account store.

## Interface
- N_MODES, 4, number of wash modes in the price table (≥2)
- DIGITS, 3, BCD magnitude digits for money values
- TICK_DIV, 100_000_000, clk cycles per 1 s tick
- GRACE_S, 8, grace seconds, also bar width (1..16)
- FINE_PERIOD_S, 1, seconds between idle fines (≥1)

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- on  in  1  machine powered; low forces IDLE
- confirm  in  1  single-cycle debounced button pulse
- mode  in  $clog2(N_MODES)  selected mode
- price_tbl  in  N_MODES*4*DIGITS  packed BCD prices, entry i at bits [i*4*DIGITS +: 4*DIGITS]
- fine  in  4*DIGITS  BCD idle-fine amount
- bal_in  in  4*DIGITS+1  {sign, BCD magnitude}; sign=1 negative
- disp  out  4*(DIGITS+1)  digit codes MS first: sign digit then magnitude; code 10 = '-', 11 = blank
- st_light  out  8  status lamps
- wt_light  out  GRACE_S  remaining-grace bar, LSB-filled
- buzz_en  out  1  buzzer enable
- bal_out  out  4*DIGITS+1  {sign, magnitude} written back
- bal_we  out  1  one-cycle write strobe
- next  out  1  one-cycle pulse: job billed and released

## Operation
- States: IDLE, QUOTE, GRACE, FINE, DONE.
- IDLE: disp all blank, st_light 0, wt_light all ones. on=1 → QUOTE.
- QUOTE: price latched every cycle from price_tbl[mode] (mode ≥ N_MODES → price 0). Each tick toggles display between balance (blank sign if positive, '-' if negative) and price (sign digit '-'). buzz_en=1, st_light=8'b0100_0000. confirm → result = bal_in − price, registered into working balance; → GRACE with countdown=GRACE_S, tick counter cleared.
- GRACE: disp = working balance; st_light=8'b1000_0000; wt_light has `countdown` low bits set. Each tick decrements countdown; when 0 → FINE. confirm → DONE.
- FINE: every FINE_PERIOD_S ticks, working balance −= fine. wt_light=0, st_light=0. confirm → DONE.
- DONE: bal_out=working balance, bal_we and next pulse exactly once on entry. disp rotates digit code 8 across the DIGITS+1 positions (others blank), one step per tick. Stays until on=0.
- on=0 in any state → IDLE next cycle, no write-back.
- Arithmetic: signed-magnitude BCD; result magnitude saturates at all-9s with sign kept; −0 normalised to +0.

## Timing
- Reset: state IDLE, disp all 11, st_light 0, wt_light all ones, buzz_en 0, bal_we 0, next 0, bal_out 0, counters 0.
- All outputs registered; disp reflects state change one cycle after transition.
- confirm sampled every cycle; confirm coinciding with a tick in GRACE → DONE takes priority over decrement/FINE entry.
- confirm coinciding with a fine tick in FINE: fine applied first, then DONE (balance includes that fine).
- confirm in QUOTE: deduction happens on the confirm cycle; GRACE entered next cycle.
- Tick counter restarts at 0 on every state entry; first tick TICK_DIV cycles after entry.
- Grace of GRACE_S ticks, then first fine FINE_PERIOD_S ticks after FINE entry.

## Structure
- Shared package: state enum, digit codes DIG_MINUS=10, DIG_BLANK=11, st_light patterns.
- Sub-module `bcd_addsub`: combinational signed-magnitude BCD subtract with saturation, width DIGITS; instantiated once, operands muxed by state.
- Tick divider and countdown inline.

## Test plan (TICK_DIV=4, DIGITS=3, GRACE_S=3, FINE_PERIOD_S=2)
- Reset then on=1, mode=1, price_tbl[1]=045, bal_in=+196 → disp alternates {11,1,9,6}/{10,0,4,5} every 4 cycles, buzz_en=1.
- confirm in QUOTE with above → GRACE, disp {11,1,5,1}, wt_light 111→011→001→000 per tick.
- Confirm in GRACE at countdown=2 → one bal_we/next pulse, bal_out=+151, no fine.
- bal_in=+010, price 045, let grace expire, fine=028 → disp −035, then −063, −091; confirm → bal_out=−091.
- bal_in=−990, price 045 → saturates to −999; mode=N_MODES-out-of-range (if N_MODES=3, mode=3) → price 000.
- on=0 mid-FINE → IDLE next cycle, bal_we never asserted; rst=1 mid-GRACE → all outputs at reset values next cycle.

Source files
------------

// File: rtl/wash_billing_n_pkg.sv
// Shared definitions for the wash billing controller.
// Holds the FSM state type, the display digit codes, and the status-lamp
// patterns shown in each phase of a job.
package wash_billing_n_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StQuote,
    StGrace,
    StFine,
    StDone
  } state_e;

  // Display digit codes beyond 0-9
  localparam logic [3:0] DIG_EIGHT = 4'd8;
  localparam logic [3:0] DIG_MINUS = 4'd10;
  localparam logic [3:0] DIG_BLANK = 4'd11;

  // Status lamp patterns
  localparam logic [7:0] ST_OFF   = 8'b0000_0000;
  localparam logic [7:0] ST_QUOTE = 8'b0100_0000;
  localparam logic [7:0] ST_GRACE = 8'b1000_0000;

endpackage

// File: rtl/wash_billing_n_if.sv
// Front-end bus of the wash billing controller.
// master: machine-side environment (drives on/confirm/mode/prices/balance in,
//         observes display, lamps, buzzer and balance write-back).
// slave : the billing controller itself.
interface wash_billing_n_if #(
  parameter int unsigned N_MODES = 4,
  parameter int unsigned DIGITS  = 3,
  parameter int unsigned GRACE_S = 8
);

  localparam int unsigned MODE_W = $clog2(N_MODES);

  logic                          on;
  logic                          confirm;
  logic [MODE_W-1:0]             mode;
  logic [N_MODES*4*DIGITS-1:0]   price_tbl;
  logic [4*DIGITS-1:0]           fine;
  logic [4*DIGITS:0]             bal_in;
  logic [4*(DIGITS+1)-1:0]       disp;
  logic [7:0]                    st_light;
  logic [GRACE_S-1:0]            wt_light;
  logic                          buzz_en;
  logic [4*DIGITS:0]             bal_out;
  logic                          bal_we;
  logic                          next;

  modport master (
    output on, confirm, mode, price_tbl, fine, bal_in,
    input  disp, st_light, wt_light, buzz_en, bal_out, bal_we, next
  );

  modport slave (
    input  on, confirm, mode, price_tbl, fine, bal_in,
    output disp, st_light, wt_light, buzz_en, bal_out, bal_we, next
  );

endinterface

// File: rtl/wash_billing_n_bcd_addsub.sv
// Combinational signed-magnitude BCD subtract: y = a - b, b non-negative.
// Ports:
//   a_sign, a_mag : minuend {sign, BCD magnitude}, sign=1 negative
//   b_mag         : subtrahend BCD magnitude
//   y_sign, y_mag : result; magnitude saturates at all-9s, zero is always +0
module wash_billing_n_bcd_addsub #(
  parameter int unsigned DIGITS = 3
) (
  input  logic                a_sign,
  input  logic [4*DIGITS-1:0] a_mag,
  input  logic [4*DIGITS-1:0] b_mag,
  output logic                y_sign,
  output logic [4*DIGITS-1:0] y_mag
);

  localparam int unsigned MAG_W = 4 * DIGITS;
  localparam logic [MAG_W-1:0] ALL_NINES = {DIGITS{4'h9}};

  // Returns {carry_out, sum}
  function automatic logic [MAG_W:0] bcd_add(input logic [MAG_W-1:0] x,
                                             input logic [MAG_W-1:0] y);
    logic             c;
    logic [4:0]       s;
    logic [MAG_W-1:0] r;
    c = 1'b0;
    r = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      s = {1'b0, x[4*i +: 4]} + {1'b0, y[4*i +: 4]} + {4'b0, c};
      if (s > 5'd9) begin
        s = s - 5'd10;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[4*i +: 4] = s[3:0];
    end
    return {c, r};
  endfunction

  // x - y, caller guarantees x >= y
  function automatic logic [MAG_W-1:0] bcd_sub(input logic [MAG_W-1:0] x,
                                               input logic [MAG_W-1:0] y);
    logic             bw;
    logic [4:0]       d;
    logic [MAG_W-1:0] r;
    bw = 1'b0;
    r  = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      d = {1'b0, x[4*i +: 4]} - {1'b0, y[4*i +: 4]} - {4'b0, bw};
      // Negative digit wraps in 5 bits; adding 10 restores the BCD digit
      if (d[4]) begin
        d  = d + 5'd10;
        bw = 1'b1;
      end else begin
        bw = 1'b0;
      end
      r[4*i +: 4] = d[3:0];
    end
    return r;
  endfunction

  logic [MAG_W:0] sum;

  always_comb begin
    sum    = bcd_add(a_mag, b_mag);
    y_sign = 1'b0;
    y_mag  = '0;
    if (a_sign) begin
      // Negative minus positive grows the magnitude
      y_sign = 1'b1;
      y_mag  = sum[MAG_W] ? ALL_NINES : sum[MAG_W-1:0];
    end else if (a_mag >= b_mag) begin
      // Packed BCD orders the same as binary, so >= compares magnitudes
      y_sign = 1'b0;
      y_mag  = bcd_sub(a_mag, b_mag);
    end else begin
      y_sign = 1'b1;
      y_mag  = bcd_sub(b_mag, a_mag);
    end
    if (y_mag == '0) begin
      y_sign = 1'b0;
    end
  end

endmodule

// File: rtl/wash_billing_n.sv
// Billing controller for the washing-machine front end.
// Quotes a price from an N-entry BCD table, deducts it from the account on
// confirm, counts down a pickup grace period on the water-light bar, then
// charges a repeating idle fine until the job is collected. Releasing the job
// writes the working balance back and pulses next.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of wash_billing_n_if (inputs on/confirm/mode/
//              price_tbl/fine/bal_in; outputs disp/st_light/wt_light/buzz_en/
//              bal_out/bal_we/next, all registered)
module wash_billing_n
  import wash_billing_n_pkg::*;
#(
  parameter int unsigned N_MODES       = 4,
  parameter int unsigned DIGITS        = 3,
  parameter int unsigned TICK_DIV      = 100_000_000,
  parameter int unsigned GRACE_S       = 8,
  parameter int unsigned FINE_PERIOD_S = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  wash_billing_n_if.slave        bus
);

  localparam int unsigned MAG_W  = 4 * DIGITS;
  localparam int unsigned DISP_W = 4 * (DIGITS + 1);
  localparam int unsigned MODE_W = $clog2(N_MODES);
  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned FINE_W = (FINE_PERIOD_S > 1) ? $clog2(FINE_PERIOD_S) : 1;
  localparam int unsigned ROT_W  = $clog2(DIGITS + 1);
  localparam int unsigned CNT_W  = 5;

  state_e            state_q, state_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [FINE_W-1:0] fine_cnt_q, fine_cnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ROT_W-1:0]  rot_q, rot_d;
  logic              show_price_q, show_price_d;
  logic              entry_q;
  logic [MAG_W-1:0]  price_q, price_d;
  logic [MAG_W:0]    work_q, work_d;

  logic [DISP_W-1:0]  disp_q, disp_d;
  logic [7:0]         st_light_q, st_light_d;
  logic [GRACE_S-1:0] wt_light_q, wt_light_d;
  logic               buzz_q, buzz_d;
  logic [MAG_W:0]     bal_out_q, bal_out_d;
  logic               bal_we_q, bal_we_d;

  logic              tick;
  logic [MAG_W-1:0]  price_sel;
  logic              op_a_sign;
  logic [MAG_W-1:0]  op_a_mag;
  logic [MAG_W-1:0]  op_b_mag;
  logic              res_sign;
  logic [MAG_W-1:0]  res_mag;

  assign tick = (tick_cnt_q == TICK_W'(TICK_DIV - 1));

  // Out-of-range modes select a zero price
  always_comb begin
    price_sel = '0;
    for (int i = 0; i < int'(N_MODES); i++) begin
      if (bus.mode == MODE_W'(i)) begin
        price_sel = bus.price_tbl[i*MAG_W +: MAG_W];
      end
    end
  end

  // One subtractor: quote deducts price from the account, fine phase deducts
  // the fine from the working balance.
  always_comb begin
    if (state_q == StQuote) begin
      op_a_sign = bus.bal_in[MAG_W];
      op_a_mag  = bus.bal_in[MAG_W-1:0];
      op_b_mag  = price_q;
    end else begin
      op_a_sign = work_q[MAG_W];
      op_a_mag  = work_q[MAG_W-1:0];
      op_b_mag  = bus.fine;
    end
  end

  wash_billing_n_bcd_addsub #(
    .DIGITS (DIGITS)
  ) u_addsub (
    .a_sign (op_a_sign),
    .a_mag  (op_a_mag),
    .b_mag  (op_b_mag),
    .y_sign (res_sign),
    .y_mag  (res_mag)
  );

  // Next state and counters
  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick ? '0 : tick_cnt_q + 1'b1;
    fine_cnt_d   = fine_cnt_q;
    cnt_d        = cnt_q;
    rot_d        = rot_q;
    show_price_d = show_price_q;
    price_d      = price_q;
    work_d       = work_q;

    unique case (state_q)
      StIdle: begin
        price_d = price_sel;
        if (bus.on) state_d = StQuote;
      end
      StQuote: begin
        price_d = price_sel;
        if (tick) show_price_d = ~show_price_q;
        if (bus.confirm) begin
          work_d  = {res_sign, res_mag};
          state_d = StGrace;
        end
      end
      StGrace: begin
        // Confirm wins over a coinciding tick
        if (bus.confirm) begin
          state_d = StDone;
        end else if (tick) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = StFine;
        end
      end
      StFine: begin
        // A fine due on the confirm cycle is still charged
        if (tick) begin
          if (fine_cnt_q == FINE_W'(FINE_PERIOD_S - 1)) begin
            fine_cnt_d = '0;
            work_d     = {res_sign, res_mag};
          end else begin
            fine_cnt_d = fine_cnt_q + 1'b1;
          end
        end
        if (bus.confirm) state_d = StDone;
      end
      StDone: begin
        if (tick) rot_d = (rot_q == ROT_W'(DIGITS)) ? '0 : rot_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (!bus.on) state_d = StIdle;

    // Every state entry restarts the tick phase and per-state counters
    if (state_d != state_q) begin
      tick_cnt_d   = '0;
      fine_cnt_d   = '0;
      rot_d        = '0;
      show_price_d = 1'b0;
      cnt_d        = CNT_W'(GRACE_S);
    end
  end

  // Outputs from the current state, registered below
  always_comb begin
    disp_d     = {(DIGITS + 1){DIG_BLANK}};
    st_light_d = ST_OFF;
    wt_light_d = '1;
    buzz_d     = 1'b0;
    bal_we_d   = 1'b0;
    bal_out_d  = bal_out_q;

    unique case (state_q)
      StIdle: ;
      StQuote: begin
        buzz_d     = 1'b1;
        st_light_d = ST_QUOTE;
        if (show_price_q) begin
          disp_d = {DIG_MINUS, price_q};
        end else begin
          disp_d = {bus.bal_in[MAG_W] ? DIG_MINUS : DIG_BLANK, bus.bal_in[MAG_W-1:0]};
        end
      end
      StGrace: begin
        st_light_d = ST_GRACE;
        disp_d     = {work_q[MAG_W] ? DIG_MINUS : DIG_BLANK, work_q[MAG_W-1:0]};
        for (int i = 0; i < int'(GRACE_S); i++) begin
          wt_light_d[i] = (CNT_W'(i) < cnt_q);
        end
      end
      StFine: begin
        wt_light_d = '0;
        disp_d     = {work_q[MAG_W] ? DIG_MINUS : DIG_BLANK, work_q[MAG_W-1:0]};
      end
      StDone: begin
        wt_light_d = '0;
        // Digit position 0 is the sign digit (most significant nibble)
        for (int i = 0; i <= int'(DIGITS); i++) begin
          disp_d[(int'(DIGITS) - i)*4 +: 4] = (rot_q == ROT_W'(i)) ? DIG_EIGHT : DIG_BLANK;
        end
        if (entry_q && bus.on) begin
          bal_we_d  = 1'b1;
          bal_out_d = work_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      tick_cnt_q   <= '0;
      fine_cnt_q   <= '0;
      cnt_q        <= '0;
      rot_q        <= '0;
      show_price_q <= 1'b0;
      entry_q      <= 1'b0;
      price_q      <= '0;
      work_q       <= '0;
      disp_q       <= {(DIGITS + 1){DIG_BLANK}};
      st_light_q   <= ST_OFF;
      wt_light_q   <= '1;
      buzz_q       <= 1'b0;
      bal_out_q    <= '0;
      bal_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      fine_cnt_q   <= fine_cnt_d;
      cnt_q        <= cnt_d;
      rot_q        <= rot_d;
      show_price_q <= show_price_d;
      entry_q      <= (state_d != state_q);
      price_q      <= price_d;
      work_q       <= work_d;
      disp_q       <= disp_d;
      st_light_q   <= st_light_d;
      wt_light_q   <= wt_light_d;
      buzz_q       <= buzz_d;
      bal_out_q    <= bal_out_d;
      bal_we_q     <= bal_we_d;
    end
  end

  assign bus.disp     = disp_q;
  assign bus.st_light = st_light_q;
  assign bus.wt_light = wt_light_q;
  assign bus.buzz_en  = buzz_q;
  assign bus.bal_out  = bal_out_q;
  assign bus.bal_we   = bal_we_q;
  assign bus.next     = bal_we_q;

endmodule

// File: tb/tb_wash_billing_n.sv
// Testbench for wash_billing_n: directed scenarios plus random stimulus,
// checked every cycle against an integer-arithmetic model of the billing rules.
module tb_wash_billing_n;

  localparam int N     = 3;
  localparam int D     = 3;
  localparam int TD    = 4;
  localparam int GS    = 3;
  localparam int FP    = 2;
  localparam int MAG_W = 4 * D;
  localparam int DSP_W = 4 * (D + 1);
  localparam int MAXV  = 10 ** D - 1;

  localparam int MI = 0, MQ = 1, MG = 2, MF = 3, MD = 4;

  logic clk;
  logic rst;

  wash_billing_n_if #(.N_MODES(N), .DIGITS(D), .GRACE_S(GS)) bus ();

  wash_billing_n #(
    .N_MODES       (N),
    .DIGITS        (D),
    .TICK_DIV      (TD),
    .GRACE_S       (GS),
    .FINE_PERIOD_S (FP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int bcd2int(input logic [MAG_W-1:0] m);
    int r;
    r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(m[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [MAG_W-1:0] int2bcd(input int v);
    logic [MAG_W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int sm2int(input logic [MAG_W:0] x);
    return x[MAG_W] ? -bcd2int(x[MAG_W-1:0]) : bcd2int(x[MAG_W-1:0]);
  endfunction

  function automatic int clamp(input int v);
    if (v > MAXV) return MAXV;
    if (v < -MAXV) return -MAXV;
    return v;
  endfunction

  function automatic logic [MAG_W:0] int2sm(input int v);
    return {v < 0, int2bcd(v < 0 ? -v : v)};
  endfunction

  function automatic logic [DSP_W-1:0] disp_of(input int v);
    return {(v < 0) ? 4'hA : 4'hB, int2bcd(v < 0 ? -v : v)};
  endfunction

  function automatic int price_of(input logic [1:0] m);
    if (int'(m) >= N) return 0;
    return bcd2int(bus.price_tbl[int'(m)*MAG_W +: MAG_W]);
  endfunction

  function automatic logic [MAG_W-1:0] rand_bcd();
    logic [MAG_W-1:0] r;
    for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Model: phase, cycles spent in the phase, balances as plain integers
  int               m_st, m_el, m_bal, m_price;
  logic [MAG_W:0]   m_bal_out;
  logic [DSP_W-1:0] e_disp;
  logic [7:0]       e_st;
  logic [GS-1:0]    e_wt;
  logic             e_buzz, e_we;
  logic [MAG_W:0]   e_bal_out;

  always @(posedge clk) begin : model
    int  nst;
    int  ticks;
    bit  tick;
    if (rst) begin
      e_disp    = 16'hBBBB;
      e_st      = '0;
      e_wt      = '1;
      e_buzz    = 1'b0;
      e_we      = 1'b0;
      m_st      = MI;
      m_el      = 0;
      m_bal     = 0;
      m_price   = 0;
      m_bal_out = '0;
      e_bal_out = '0;
    end else begin
      ticks  = m_el / TD;
      tick   = (m_el % TD) == TD - 1;
      e_disp = 16'hBBBB;
      e_st   = '0;
      e_wt   = '1;
      e_buzz = 1'b0;
      e_we   = 1'b0;
      case (m_st)
        MQ: begin
          e_buzz = 1'b1;
          e_st   = 8'h40;
          if (ticks % 2 == 1) e_disp = {4'hA, int2bcd(m_price)};
          else e_disp = {bus.bal_in[MAG_W] ? 4'hA : 4'hB, bus.bal_in[MAG_W-1:0]};
        end
        MG: begin
          e_st   = 8'h80;
          e_disp = disp_of(m_bal);
          e_wt   = GS'((1 << (GS - ticks)) - 1);
        end
        MF: begin
          e_wt   = '0;
          e_disp = disp_of(m_bal);
        end
        MD: begin
          e_wt = '0;
          for (int i = 0; i <= D; i++)
            e_disp[(D - i)*4 +: 4] = (i == ticks % (D + 1)) ? 4'h8 : 4'hB;
          if (m_el == 0 && bus.on) begin
            e_we      = 1'b1;
            m_bal_out = int2sm(m_bal);
          end
        end
        default: ;
      endcase
      e_bal_out = m_bal_out;

      nst = m_st;
      if (!bus.on) begin
        nst = MI;
      end else begin
        case (m_st)
          MI: nst = MQ;
          MQ: if (bus.confirm) begin
            m_bal = clamp(sm2int(bus.bal_in) - m_price);
            nst   = MG;
          end
          MG: begin
            if (bus.confirm) nst = MD;
            else if (tick && ticks + 1 == GS) nst = MF;
          end
          MF: begin
            if (tick && (ticks + 1) % FP == 0) m_bal = clamp(m_bal - bcd2int(bus.fine));
            if (bus.confirm) nst = MD;
          end
          default: ;
        endcase
      end
      if (m_st == MI || m_st == MQ) m_price = price_of(bus.mode);
      if (nst != m_st) m_el = 0;
      else m_el++;
      m_st = nst;
    end
    #1;
    chk("disp", bus.disp, e_disp);
    chk("st_light", bus.st_light, e_st);
    chk("wt_light", bus.wt_light, e_wt);
    chk("buzz_en", bus.buzz_en, e_buzz);
    chk("bal_we", bus.bal_we, e_we);
    chk("next", bus.next, e_we);
    chk("bal_out", bus.bal_out, e_bal_out);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_disp(input string nm, input logic [DSP_W-1:0] target, input int budget);
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (bus.disp == target) break;
    end
    chk(nm, bus.disp, target);
  endtask

  task automatic quote_and_confirm();
    bus.on = 1'b1;
    step(3);
    bus.confirm = 1'b1;
    step(1);
    bus.confirm = 1'b0;
  endtask

  int we_seen;

  initial begin
    rst           = 1'b1;
    bus.on        = 1'b0;
    bus.confirm   = 1'b0;
    bus.mode      = 2'd0;
    bus.price_tbl = {12'h300, 12'h045, 12'h123};
    bus.fine      = 12'h028;
    bus.bal_in    = 13'h0196;
    step(2);
    chk("rst_disp", bus.disp, 16'hBBBB);
    chk("rst_wt", bus.wt_light, 3'b111);
    chk("rst_st", bus.st_light, 8'h00);
    chk("rst_bal_out", bus.bal_out, 13'h0000);

    // Quote alternates balance and price
    rst      = 1'b0;
    bus.on   = 1'b1;
    bus.mode = 2'd1;
    step(2);
    chk("quote_bal", bus.disp, 16'hB196);
    chk("quote_buzz", bus.buzz_en, 1'b1);
    step(4);
    chk("quote_price", bus.disp, 16'hA045);

    // Confirm, then collect during grace
    bus.confirm = 1'b1;
    step(1);
    bus.confirm = 1'b0;
    step(1);
    chk("grace_disp", bus.disp, 16'hB151);
    chk("grace_wt0", bus.wt_light, 3'b111);
    step(4);
    chk("grace_wt1", bus.wt_light, 3'b011);
    bus.confirm = 1'b1;
    step(1);
    bus.confirm = 1'b0;
    step(1);
    chk("done_we", bus.bal_we, 1'b1);
    chk("done_bal_out", bus.bal_out, 13'h0151);
    step(1);
    chk("done_we_once", bus.bal_we, 1'b0);

    // Grace expires, fines accumulate
    bus.on     = 1'b0;
    bus.bal_in = 13'h0010;
    step(2);
    quote_and_confirm();
    step(2);
    chk("neg_result", bus.disp, 16'hA035);
    wait_disp("fine1", 16'hA063, 60);
    wait_disp("fine2", 16'hA091, 60);
    bus.confirm = 1'b1;
    step(1);
    bus.confirm = 1'b0;
    step(1);
    chk("fine_we", bus.bal_we, 1'b1);
    chk("fine_bal_out", bus.bal_out, 13'h1091);

    // Saturation and out-of-range mode
    bus.on     = 1'b0;
    bus.bal_in = 13'h1990;
    step(2);
    quote_and_confirm();
    step(2);
    chk("saturate", bus.disp, 16'hA999);
    bus.on     = 1'b0;
    bus.mode   = 2'd3;
    bus.bal_in = 13'h0123;
    step(2);
    bus.on = 1'b1;
    step(6);
    chk("mode_oob_price", bus.disp, 16'hA000);

    // Power drop mid-fine: no write-back
    bus.on     = 1'b0;
    bus.mode   = 2'd0;
    bus.bal_in = 13'h0100;
    step(2);
    quote_and_confirm();
    step(20);
    chk("in_fine_wt", bus.wt_light, 3'b000);
    bus.on  = 1'b0;
    we_seen = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      we_seen += int'(bus.bal_we);
    end
    chk("no_writeback", we_seen, 0);
    chk("off_disp", bus.disp, 16'hBBBB);

    // Reset mid-grace
    quote_and_confirm();
    step(3);
    rst = 1'b1;
    step(1);
    chk("rst2_disp", bus.disp, 16'hBBBB);
    chk("rst2_wt", bus.wt_light, 3'b111);
    chk("rst2_st", bus.st_light, 8'h00);
    chk("rst2_buzz", bus.buzz_en, 1'b0);
    chk("rst2_bal_out", bus.bal_out, 13'h0000);
    rst = 1'b0;

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0) begin
        bus.mode      = 2'($urandom_range(0, 3));
        bus.bal_in    = {1'($urandom_range(0, 1)), rand_bcd()};
        bus.fine      = rand_bcd();
        bus.price_tbl = {rand_bcd(), rand_bcd(), rand_bcd()};
      end
      bus.on      = ($urandom_range(0, 299) != 0);
      bus.confirm = ($urandom_range(0, 19) == 0);
      rst         = ($urandom_range(0, 999) == 0);
      step(1);
    end
    rst         = 1'b0;
    bus.confirm = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
